// File: rtl/light_pkg.sv
// rtl/light_pkg.sv - shared traffic-light phase codes, defaults and decode helpers
package light_pkg;

    typedef enum logic [2:0] {
        OFF = 3'd0,
        GA  = 3'd1,
        G   = 3'd2,
        Y   = 3'd3,
        R   = 3'd4,
        ILL = 3'd7
    } phase_t;

    localparam int TICK_DIV_DEFAULT = 50_000_000;

    // lamps = {green, arrow, red, yellow}
    function automatic phase_t decode_lamps(input logic [3:0] lamps);
        phase_t p;
        case (lamps)
            4'b0000: p = OFF;
            4'b1100: p = GA;
            4'b1000: p = G;
            4'b0001: p = Y;
            4'b0010: p = R;
            default: p = ILL;
        endcase
        return p;
    endfunction

    function automatic phase_t legal_next(input phase_t p);
        phase_t n;
        case (p)
            OFF:     n = GA;
            GA:      n = G;
            G:       n = Y;
            Y:       n = R;
            R:       n = OFF;
            default: n = ILL;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/light_tick_gen.sv
// rtl/light_tick_gen.sv - prescaler issuing one tick per TICK_DIV clocks
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the prescaler
//   tick     : high during the last count of each TICK_DIV period
module light_tick_gen #(
    parameter int TICK_DIV = light_pkg::TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Tick is still visible in the cycle a clear is requested, so the
    // period ending exactly at a boundary is counted for the old phase.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/light_phase_monitor.sv
// rtl/light_phase_monitor.sv - decodes lamp outputs into phases, reports durations, flags errors
//   clk, rst                 : clock, asynchronous active-high reset
//   green/arrow/red/yellow   : lamp outputs of the light controller
//   phase                    : current decoded phase code
//   rpt_valid/phase/ticks    : one-cycle report of the phase just ended
//   seq_err, pat_err         : one-cycle pulses for out-of-order / illegal pattern
//   err_count                : saturating error count
//   synced                   : a first phase boundary has been seen
module light_phase_monitor
    import light_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int DUR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             green,
    input  logic             arrow,
    input  logic             red,
    input  logic             yellow,
    output logic [2:0]       phase,
    output logic             rpt_valid,
    output logic [2:0]       rpt_phase,
    output logic [DUR_W-1:0] rpt_ticks,
    output logic             seq_err,
    output logic             pat_err,
    output logic [7:0]       err_count,
    output logic             synced
);

    logic [3:0]       lamp_q;
    phase_t           phase_q,     phase_d;
    phase_t           dec;
    logic             boundary;
    logic             tick;
    logic [DUR_W-1:0] tick_cnt_q,  tick_cnt_d, tick_cnt_inc;
    logic             synced_q,    synced_d;
    logic             rpt_valid_q, rpt_valid_d;
    logic [2:0]       rpt_phase_q, rpt_phase_d;
    logic [DUR_W-1:0] rpt_ticks_q, rpt_ticks_d;
    logic             seq_err_q,   seq_err_d;
    logic             pat_err_q,   pat_err_d;
    logic [7:0]       err_count_q, err_count_d;

    assign dec      = decode_lamps(lamp_q);
    assign boundary = (dec != phase_q);

    light_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (boundary),
        .tick(tick)
    );

    // Includes a tick landing on this very edge so a report covers
    // floor(length / TICK_DIV) complete periods.
    assign tick_cnt_inc = (tick && (tick_cnt_q != {DUR_W{1'b1}}))
                        ? tick_cnt_q + DUR_W'(1) : tick_cnt_q;

    always_comb begin
        phase_d     = phase_q;
        synced_d    = synced_q;
        tick_cnt_d  = tick_cnt_inc;
        rpt_valid_d = 1'b0;
        rpt_phase_d = rpt_phase_q;
        rpt_ticks_d = rpt_ticks_q;
        seq_err_d   = 1'b0;
        pat_err_d   = 1'b0;
        err_count_d = err_count_q;

        if (boundary) begin
            phase_d    = dec;
            tick_cnt_d = '0;
            if (!synced_q) begin
                // Phase in progress at reset has unknown length: just sync.
                synced_d = 1'b1;
            end else if ((phase_q != ILL) && (dec != ILL)) begin
                rpt_valid_d = 1'b1;
                rpt_phase_d = phase_q;
                rpt_ticks_d = tick_cnt_inc;
                seq_err_d   = (dec != legal_next(phase_q));
            end
            // Leaving ILL falls through with no report and no check.
            pat_err_d = (dec == ILL);
        end

        if ((seq_err_d || pat_err_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamp_q      <= '0;
            phase_q     <= OFF;
            synced_q    <= 1'b0;
            tick_cnt_q  <= '0;
            rpt_valid_q <= 1'b0;
            rpt_phase_q <= '0;
            rpt_ticks_q <= '0;
            seq_err_q   <= 1'b0;
            pat_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            lamp_q      <= {green, arrow, red, yellow};
            phase_q     <= phase_d;
            synced_q    <= synced_d;
            tick_cnt_q  <= tick_cnt_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_phase_q <= rpt_phase_d;
            rpt_ticks_q <= rpt_ticks_d;
            seq_err_q   <= seq_err_d;
            pat_err_q   <= pat_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign phase     = phase_q;
    assign synced    = synced_q;
    assign rpt_valid = rpt_valid_q;
    assign rpt_phase = rpt_phase_q;
    assign rpt_ticks = rpt_ticks_q;
    assign seq_err   = seq_err_q;
    assign pat_err   = pat_err_q;
    assign err_count = err_count_q;

endmodule

// File: doc/light_phase_monitor.md
LIGHT_PHASE_MONITOR -- requirements
Module: light_phase_monitor

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, giving clk cycles per duration tick (1 s at 50 MHz).
REQ-002 SHALL have parameter DUR_W, default 8, giving the width of the duration report.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports green, arrow, red, yellow, input, 1 each, the lamp outputs of the traffic-light controller, synchronous to clk.
REQ-006 SHALL have port phase, output, 3, the currently decoded phase code.
REQ-007 SHALL have port rpt_valid, output, 1, a one-cycle pulse marking a completed-phase report.
REQ-008 SHALL have port rpt_phase, output, 3, the code of the phase just ended; valid only with rpt_valid.
REQ-009 SHALL have port rpt_ticks, output, DUR_W, the duration of the phase just ended in whole ticks; valid only with rpt_valid.
REQ-010 SHALL have port seq_err, output, 1, a one-cycle pulse on an out-of-order transition.
REQ-011 SHALL have port pat_err, output, 1, a one-cycle pulse on entry to an illegal lamp pattern.
REQ-012 SHALL have port err_count, output, 8, the saturating count of seq_err plus pat_err events.
REQ-013 SHALL have port synced, output, 1, high once a first phase boundary has been observed.

Function
REQ-014 SHALL register the four lamp inputs once (lamp_q) and decode only lamp_q.
REQ-015 SHALL decode lamp_q patterns (green, arrow, red, yellow) as follows: 0000 gives OFF=0; 1100 gives GA=1; 1000 gives G=2; 0001 gives Y=3; 0010 gives R=4; any other pattern gives ILL=7.
REQ-016 SHALL detect a phase boundary when the decoded phase differs from the phase register, and update phase at the next edge, so that phase follows an input change by exactly 2 clk.
REQ-017 SHALL accept only this legal successor order: OFF to GA, GA to G, G to Y, Y to R, R to OFF.
REQ-018 SHALL, at each boundary with synced=1 and old phase not ILL, pulse rpt_valid with rpt_phase equal to the old phase and rpt_ticks equal to its tick count, in the same cycle phase updates.
REQ-019 SHALL NOT report the first boundary after reset; that boundary only sets synced=1, with no sequence check.
REQ-020 SHALL pulse seq_err at a boundary when synced=1, the old phase is legal, the new phase is legal, and the new phase is not the legal successor; the report for the old phase is still issued.
REQ-021 SHALL pulse pat_err on entry to ILL, with no seq_err in that same cycle.
REQ-022 SHALL produce no report when leaving ILL.
REQ-023 SHALL, on leaving ILL to any legal phase, resynchronise with no seq_err.
REQ-024 SHALL hold phase at 7 while in ILL.
REQ-025 SHALL run a prescaler counting 0..TICK_DIV-1 that issues one tick per wrap.
REQ-026 SHALL clear the prescaler and the tick counter at every boundary, so rpt_ticks equals floor(phase-length cycles / TICK_DIV).
REQ-027 SHALL saturate the tick counter at 2^DUR_W-1 with no wrap.
REQ-028 SHALL increment err_count by 1 per cycle in which seq_err or pat_err is high (the two are never high together), saturating at 255.
REQ-029 SHALL hold phase and the counters unchanged while the lamp pattern is stable.

Reset
REQ-030 SHALL, on rst asserted asynchronously, force lamp_q=0, phase=0, rpt_valid=0, rpt_phase=0, rpt_ticks=0, seq_err=0, pat_err=0, err_count=0, synced=0, prescaler=0 and tick counter=0.
REQ-031 SHALL discard any phase in progress when rst is asserted mid-phase; the first boundary after release is treated per REQ-019.

Structure
REQ-032 SHALL take phase codes OFF, GA, G, Y, R and ILL and the TICK_DIV default from shared package light_pkg, which the traffic-light controller also uses.
REQ-033 SHALL instantiate one sub-module, light_tick_gen (prescaler with synchronous clear input and one-cycle tick output).
REQ-034 SHALL keep the remaining logic (sampling, decode, phase FSM, checks, counters) in light_phase_monitor, at 120-400 RTL lines.

Verification (TICK_DIV=4, DUR_W=8)
REQ-035 SHALL cover the legal cycle: reset, OFF 8 clk, GA 12 clk, G 20 clk, Y 8 clk, R 16 clk, OFF. Required response: the first boundary is not reported; then reports (1,3), (2,5), (3,2), (4,4); seq_err=0 and err_count=0 throughout.
REQ-036 SHALL cover skip-yellow: a synced G held 8 clk, then R. Required response: rpt_valid with (2,2), seq_err pulse in the same cycle, err_count=1, phase=4.
REQ-037 SHALL cover an illegal pattern: synced G, then green+red (1010), then R. Required response: pat_err one cycle, phase=7, no report on entry to or exit from ILL, then phase=4 with no seq_err, err_count=1.
REQ-038 SHALL cover saturation: GA held 1200 clk. Required response: rpt_ticks=255 at the boundary; 300 forced seq_errors leave err_count at 255.
REQ-039 SHALL cover reset mid-phase: rst pulsed 3 clk in the middle of G. Required response: all outputs zero, synced=0, and the next boundary produces no rpt_valid and no seq_err.
REQ-040 SHALL cover latency: a lamp input change at edge N. Required response: phase updated and rpt_valid high after edge N+2, high for exactly one clk.
